// File: rtl/lsb_param.sv
// rtl/lsb_param.sv - in-order load/store buffer with CDB snooping, commit-gated stores and rollback
module lsb_param #(
    parameter int          DEPTH    = 16,
    parameter int          ROB_W    = 4,
    parameter int          NUM_CDB  = 2,
    parameter logic [31:0] IO_MASK  = 32'h0003_0000,
    parameter logic [31:0] IO_MATCH = 32'h0003_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     rollback,
    output logic                     lsb_nxt_full,
    output logic [$clog2(DEPTH):0]   lsb_count,
    output logic                     mc_en,
    output logic                     mc_wr,
    output logic [31:0]              mc_addr,
    output logic [2:0]               mc_len,
    output logic [31:0]              mc_w_data,
    input  logic                     mc_done,
    input  logic [31:0]              mc_r_data,
    input  logic                     issue,
    input  logic [ROB_W-1:0]         issue_rob_pos,
    input  logic                     issue_is_store,
    input  logic [2:0]               issue_funct3,
    input  logic [31:0]              issue_rs1_val,
    input  logic [31:0]              issue_rs2_val,
    input  logic [ROB_W:0]           issue_rs1_tag,
    input  logic [ROB_W:0]           issue_rs2_tag,
    input  logic [31:0]              issue_imm,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_pos,
    input  logic [NUM_CDB*32-1:0]    cdb_val,
    output logic                     result,
    output logic [ROB_W-1:0]         result_rob_pos,
    output logic [31:0]              result_val,
    input  logic                     commit_store,
    input  logic [ROB_W-1:0]         commit_rob_pos,
    input  logic [ROB_W-1:0]         head_rob_pos
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            r_state;
    logic [AW-1:0]     r_head, r_tail, r_last_commit;
    logic [AW:0]       r_count;
    logic              r_has_commit;

    logic              r_valid     [DEPTH];
    logic              r_committed [DEPTH];
    logic              r_is_store  [DEPTH];
    logic [2:0]        r_funct3    [DEPTH];
    logic [ROB_W-1:0]  r_rob_pos   [DEPTH];
    logic [31:0]       r_rs1_val   [DEPTH];
    logic [31:0]       r_rs2_val   [DEPTH];
    logic [ROB_W:0]    r_rs1_tag   [DEPTH];
    logic [ROB_W:0]    r_rs2_tag   [DEPTH];
    logic [31:0]       r_imm       [DEPTH];

    // Returns {tag, value} after snooping all buses; iterating downwards lets the lowest bus win.
    function automatic logic [ROB_W+32:0] f_snoop(input logic [ROB_W:0] tag, input logic [31:0] val);
        logic [ROB_W+32:0] v;
        v = {tag, val};
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && tag == {1'b1, cdb_rob_pos[k*ROB_W +: ROB_W]})
                v = {{(ROB_W+1){1'b0}}, cdb_val[k*32 +: 32]};
        end
        return v;
    endfunction

    function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'b0, d[7:0]};
            3'b101:  return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    logic [ROB_W:0] w_is_rs1_tag, w_is_rs2_tag;
    logic [31:0]    w_is_rs1_val, w_is_rs2_val;
    assign {w_is_rs1_tag, w_is_rs1_val} = f_snoop(issue_rs1_tag, issue_rs1_val);
    assign {w_is_rs2_tag, w_is_rs2_val} = f_snoop(issue_rs2_tag, issue_rs2_val);

    logic [31:0] w_h_addr;
    logic        w_h_io, w_h_ops_ready, w_head_ready;
    logic        w_pop, w_abort, w_issue_eff, w_keep_commit;
    logic [AW-1:0] w_new_head;

    assign w_h_addr      = r_rs1_val[r_head] + r_imm[r_head];
    assign w_h_io        = (w_h_addr & IO_MASK) == IO_MATCH;
    assign w_h_ops_ready = !r_rs1_tag[r_head][ROB_W] && !r_rs2_tag[r_head][ROB_W];
    assign w_head_ready  = r_valid[r_head] && w_h_ops_ready &&
                           (r_is_store[r_head] ? r_committed[r_head]
                                               : (!rollback && (!w_h_io || r_rob_pos[r_head] == head_rob_pos)));

    // A rollback kills an in-flight load, but a store already sent is committed and must complete.
    assign w_pop         = rdy && r_state == S_BUSY && mc_done && (r_is_store[r_head] || !rollback);
    assign w_abort       = rdy && r_state == S_BUSY && rollback && !r_is_store[r_head];
    assign w_issue_eff   = rdy && issue && !rollback;
    assign w_new_head    = r_head + AW'(w_pop);
    assign w_keep_commit = r_has_commit && !(w_pop && r_head == r_last_commit);

    assign lsb_count    = r_count;
    assign lsb_nxt_full = (r_count + (AW+1)'(w_issue_eff) - (AW+1)'(w_pop)) == (AW+1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_head         <= '0;
            r_tail         <= '0;
            r_last_commit  <= '0;
            r_count        <= '0;
            r_has_commit   <= 1'b0;
            mc_en          <= 1'b0;
            mc_wr          <= 1'b0;
            mc_addr        <= '0;
            mc_len         <= '0;
            mc_w_data      <= '0;
            result         <= 1'b0;
            result_rob_pos <= '0;
            result_val     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]     <= 1'b0;
                r_committed[i] <= 1'b0;
                r_is_store[i]  <= 1'b0;
                r_funct3[i]    <= '0;
                r_rob_pos[i]   <= '0;
                r_rs1_val[i]   <= '0;
                r_rs2_val[i]   <= '0;
                r_rs1_tag[i]   <= '0;
                r_rs2_tag[i]   <= '0;
                r_imm[i]       <= '0;
            end
        end else begin
            result <= 1'b0;
            if (rdy) begin
                for (int i = 0; i < DEPTH; i++) begin
                    {r_rs1_tag[i], r_rs1_val[i]} <= f_snoop(r_rs1_tag[i], r_rs1_val[i]);
                    {r_rs2_tag[i], r_rs2_val[i]} <= f_snoop(r_rs2_tag[i], r_rs2_val[i]);
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_head_ready) begin
                            mc_en     <= 1'b1;
                            mc_wr     <= r_is_store[r_head];
                            mc_addr   <= w_h_addr;
                            mc_len    <= (r_funct3[r_head][1:0] == 2'b00) ? 3'd1 :
                                         (r_funct3[r_head][1:0] == 2'b01) ? 3'd2 : 3'd4;
                            mc_w_data <= r_rs2_val[r_head];
                            r_state   <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (w_abort) begin
                            mc_en   <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (mc_done) begin
                            mc_en   <= 1'b0;
                            r_state <= S_IDLE;
                            if (!r_is_store[r_head]) begin
                                result         <= 1'b1;
                                result_rob_pos <= r_rob_pos[r_head];
                                result_val     <= f_extend(r_funct3[r_head], mc_r_data);
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase

                if (w_pop) begin
                    r_valid[r_head]     <= 1'b0;
                    r_committed[r_head] <= 1'b0;
                end

                if (rollback) begin
                    for (int i = 0; i < DEPTH; i++)
                        if (!r_committed[i]) r_valid[i] <= 1'b0;
                    r_head <= w_new_head;
                    if (w_keep_commit) begin
                        r_tail  <= r_last_commit + AW'(1);
                        r_count <= {1'b0, AW'(r_last_commit - w_new_head)} + (AW+1)'(1);
                    end else begin
                        r_tail       <= w_new_head;
                        r_count      <= '0;
                        r_has_commit <= 1'b0;
                    end
                end else begin
                    if (w_issue_eff) begin
                        r_valid[r_tail]     <= 1'b1;
                        r_committed[r_tail] <= 1'b0;
                        r_is_store[r_tail]  <= issue_is_store;
                        r_funct3[r_tail]    <= issue_funct3;
                        r_rob_pos[r_tail]   <= issue_rob_pos;
                        r_rs1_val[r_tail]   <= w_is_rs1_val;
                        r_rs2_val[r_tail]   <= w_is_rs2_val;
                        r_rs1_tag[r_tail]   <= w_is_rs1_tag;
                        r_rs2_tag[r_tail]   <= w_is_rs2_tag;
                        r_imm[r_tail]       <= issue_imm;
                        r_tail              <= r_tail + AW'(1);
                    end
                    r_head  <= w_new_head;
                    r_count <= r_count + (AW+1)'(w_issue_eff) - (AW+1)'(w_pop);
                    if (w_pop && r_has_commit && r_head == r_last_commit)
                        r_has_commit <= 1'b0;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (commit_store && r_valid[i] && !r_committed[i] && r_rob_pos[i] == commit_rob_pos) begin
                            r_committed[i] <= 1'b1;
                            r_last_commit  <= AW'(i);
                            r_has_commit   <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lsb_param.sv
// tb/tb_lsb_param.sv - directed self-checking bench for lsb_param
module tb_lsb_param;
    logic        clk, rst, rdy, rollback;
    logic        lsb_nxt_full;
    logic [4:0]  lsb_count;
    logic        mc_en, mc_wr;
    logic [31:0] mc_addr;
    logic [2:0]  mc_len;
    logic [31:0] mc_w_data;
    logic        mc_done;
    logic [31:0] mc_r_data;
    logic        issue;
    logic [3:0]  issue_rob_pos;
    logic        issue_is_store;
    logic [2:0]  issue_funct3;
    logic [31:0] issue_rs1_val, issue_rs2_val;
    logic [4:0]  issue_rs1_tag, issue_rs2_tag;
    logic [31:0] issue_imm;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob_pos;
    logic [63:0] cdb_val;
    logic        result;
    logic [3:0]  result_rob_pos;
    logic [31:0] result_val;
    logic        commit_store;
    logic [3:0]  commit_rob_pos, head_rob_pos;

    int checks = 0;
    int errors = 0;

    lsb_param dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .lsb_nxt_full(lsb_nxt_full), .lsb_count(lsb_count),
        .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len), .mc_w_data(mc_w_data),
        .mc_done(mc_done), .mc_r_data(mc_r_data),
        .issue(issue), .issue_rob_pos(issue_rob_pos), .issue_is_store(issue_is_store),
        .issue_funct3(issue_funct3), .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
        .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag), .issue_imm(issue_imm),
        .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
        .result(result), .result_rob_pos(result_rob_pos), .result_val(result_val),
        .commit_store(commit_store), .commit_rob_pos(commit_rob_pos), .head_rob_pos(head_rob_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_op(input logic st, input logic [3:0] rob, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [4:0] t1, input logic [31:0] imm,
                          input logic [31:0] rs2);
        issue          = 1'b1;
        issue_is_store = st;
        issue_rob_pos  = rob;
        issue_funct3   = f3;
        issue_rs1_val  = rs1;
        issue_rs1_tag  = t1;
        issue_imm      = imm;
        issue_rs2_val  = rs2;
        issue_rs2_tag  = 5'd0;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [3:0] rob,
                            input logic [31:0] rdata, input logic [31:0] expv);
        set_op(1'b0, rob, f3, 32'h40, 5'd0, 32'h0, 32'h0);
        tick();
        issue = 1'b0;
        tick();
        chk({tag, "_mc_en"}, mc_en, 1);
        mc_done = 1'b1; mc_r_data = rdata;
        tick();
        mc_done = 1'b0;
        chk({tag, "_result"}, result, 1);
        chk({tag, "_val"}, result_val, expv);
        tick();
        chk({tag, "_pulse_end"}, result, 0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; mc_done = 1'b0; mc_r_data = '0;
        issue = 1'b0; issue_rob_pos = '0; issue_is_store = 1'b0; issue_funct3 = '0;
        issue_rs1_val = '0; issue_rs2_val = '0; issue_rs1_tag = '0; issue_rs2_tag = '0; issue_imm = '0;
        cdb_valid = '0; cdb_rob_pos = '0; cdb_val = '0;
        commit_store = 1'b0; commit_rob_pos = '0; head_rob_pos = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_mc_en", mc_en, 0);
        chk("rst_result", result, 0);
        chk("rst_count", lsb_count, 0);
        chk("rst_nxt_full", lsb_nxt_full, 0);

        // LW basic path
        set_op(1'b0, 4'd1, 3'b010, 32'h100, 5'd0, 32'd4, 32'h0);
        tick();
        issue = 1'b0;
        chk("lw_count", lsb_count, 1);
        chk("lw_mc_en_early", mc_en, 0);
        tick();
        chk("lw_mc_en", mc_en, 1);
        chk("lw_addr", mc_addr, 32'h104);
        chk("lw_len", mc_len, 4);
        chk("lw_wr", mc_wr, 0);
        mc_done = 1'b1; mc_r_data = 32'hDEADBEEF;
        tick();
        mc_done = 1'b0;
        chk("lw_result", result, 1);
        chk("lw_val", result_val, 32'hDEADBEEF);
        chk("lw_rob", result_rob_pos, 1);
        chk("lw_mc_en_off", mc_en, 0);
        chk("lw_count_pop", lsb_count, 0);
        tick();
        chk("lw_pulse_end", result, 0);

        run_load("lb", 3'b000, 4'd2, 32'h0000_0080, 32'hFFFF_FF80);
        run_load("lbu", 3'b100, 4'd3, 32'h0000_0080, 32'h0000_0080);
        run_load("lh", 3'b001, 4'd4, 32'h0000_8001, 32'hFFFF_8001);
        run_load("lhu", 3'b101, 4'd5, 32'h0000_8001, 32'h0000_8001);

        // Store waits for commit
        set_op(1'b1, 4'd5, 3'b010, 32'h300, 5'd0, 32'd8, 32'hCAFEF00D);
        tick();
        issue = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sw_wait", mc_en, 0);
        end
        commit_store = 1'b1; commit_rob_pos = 4'd5;
        tick();
        commit_store = 1'b0;
        tick();
        chk("sw_mc_en", mc_en, 1);
        chk("sw_wr", mc_wr, 1);
        chk("sw_addr", mc_addr, 32'h308);
        chk("sw_data", mc_w_data, 32'hCAFEF00D);
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        chk("sw_no_result", result, 0);
        chk("sw_count", lsb_count, 0);
        tick();
        chk("sw_no_result2", result, 0);

        // Operand captured from bus 1
        set_op(1'b0, 4'd2, 3'b010, 32'h0, 5'b10011, 32'h10, 32'h0);
        tick();
        issue = 1'b0;
        tick();
        chk("cdb_pending", mc_en, 0);
        cdb_valid = 2'b10; cdb_rob_pos = {4'd3, 4'd0}; cdb_val = {32'h200, 32'h0};
        tick();
        cdb_valid = 2'b00;
        tick();
        chk("cdb_mc_en", mc_en, 1);
        chk("cdb_addr", mc_addr, 32'h210);
        mc_done = 1'b1; tick(); mc_done = 1'b0;
        tick();

        // Same-cycle issue capture, both buses match: bus 0 wins
        set_op(1'b0, 4'd7, 3'b010, 32'h0, 5'b10110, 32'h4, 32'h0);
        cdb_valid = 2'b11; cdb_rob_pos = {4'd6, 4'd6}; cdb_val = {32'h999, 32'h400};
        tick();
        issue = 1'b0; cdb_valid = 2'b00;
        tick();
        chk("issue_cdb_addr", mc_addr, 32'h404);

        // rdy=0 holds everything
        rdy = 1'b0; mc_done = 1'b1; mc_r_data = 32'h55;
        tick(); tick();
        chk("rdy_hold_en", mc_en, 1);
        chk("rdy_hold_result", result, 0);
        rdy = 1'b1;
        tick();
        mc_done = 1'b0;
        chk("rdy_resume_result", result, 1);
        chk("rdy_resume_val", result_val, 32'h55);
        tick();

        // Fill to DEPTH with pending loads
        for (int i = 0; i < 16; i++) begin
            set_op(1'b0, 4'(i), 3'b010, 32'h0, {1'b1, 4'(i)}, 32'h0, 32'h0);
            if (i == 15) begin
                #1;
                chk("full_last_issue", lsb_nxt_full, 1);
            end
            tick();
        end
        issue = 1'b0;
        #1;
        chk("full_count", lsb_count, 16);
        chk("full_hold", lsb_nxt_full, 1);
        cdb_valid = 2'b01; cdb_rob_pos = {4'd0, 4'd0}; cdb_val = {32'h0, 32'h500};
        tick();
        cdb_valid = 2'b00;
        tick();
        chk("full_head_addr", mc_addr, 32'h500);
        mc_done = 1'b1; mc_r_data = 32'h77;
        #1;
        chk("full_pop_nxt", lsb_nxt_full, 0);
        tick();
        mc_done = 1'b0;
        chk("full_pop_count", lsb_count, 15);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        chk("rb_empty_count", lsb_count, 0);
        tick();
        chk("rb_empty_idle", mc_en, 0);

        // Two committed stores plus three loads, then rollback
        set_op(1'b1, 4'd1, 3'b010, 32'h1000, 5'd0, 32'h0, 32'h11); tick();
        set_op(1'b1, 4'd2, 3'b010, 32'h2000, 5'd0, 32'h0, 32'h22); tick();
        set_op(1'b0, 4'd3, 3'b010, 32'h40, 5'd0, 32'h0, 32'h0); tick();
        set_op(1'b0, 4'd4, 3'b010, 32'h40, 5'd0, 32'h0, 32'h0); tick();
        set_op(1'b0, 4'd5, 3'b010, 32'h40, 5'd0, 32'h0, 32'h0); tick();
        issue = 1'b0;
        chk("rb_pre_count", lsb_count, 5);
        commit_store = 1'b1; commit_rob_pos = 4'd1; tick();
        commit_rob_pos = 4'd2; tick();
        commit_store = 1'b0;
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        chk("rb_count", lsb_count, 2);
        chk("rb_st1_en", mc_en, 1);
        chk("rb_st1_addr", mc_addr, 32'h1000);
        mc_done = 1'b1; tick(); mc_done = 1'b0;
        chk("rb_st1_pop", lsb_count, 1);
        tick();
        chk("rb_st2_en", mc_en, 1);
        chk("rb_st2_addr", mc_addr, 32'h2000);
        chk("rb_st2_data", mc_w_data, 32'h22);
        mc_done = 1'b1; tick(); mc_done = 1'b0;
        chk("rb_st2_pop", lsb_count, 0);
        tick(); tick();
        chk("rb_loads_gone", mc_en, 0);

        // In-flight load aborted by rollback
        set_op(1'b0, 4'd9, 3'b010, 32'h80, 5'd0, 32'h0, 32'h0);
        tick();
        issue = 1'b0;
        tick();
        chk("abort_en", mc_en, 1);
        rollback = 1'b1; mc_done = 1'b1;
        tick();
        rollback = 1'b0; mc_done = 1'b0;
        chk("abort_en_off", mc_en, 0);
        chk("abort_no_result", result, 0);
        chk("abort_count", lsb_count, 0);

        // IO load waits for ROB head
        head_rob_pos = 4'd2;
        set_op(1'b0, 4'd6, 3'b010, 32'h30000, 5'd0, 32'h0, 32'h0);
        tick();
        issue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("io_wait", mc_en, 0);
        end
        head_rob_pos = 4'd6;
        tick();
        chk("io_en", mc_en, 1);
        chk("io_addr", mc_addr, 32'h30000);
        mc_done = 1'b1; mc_r_data = 32'h1234;
        tick();
        mc_done = 1'b0;
        chk("io_result_rob", result_rob_pos, 6);
        chk("io_result_val", result_val, 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
